// File: rtl/vt100_pkg.sv
// Shared constants, control codes and state encoding for the VT100 write
// engine and the display path.
package vt100_pkg;

    localparam int COLS     = 80;
    localparam int ROWS     = 24;
    localparam int SCR_SIZE = COLS * ROWS;

    localparam logic [7:0] FILL = 8'h20;

    // Sized limits so comparisons against the narrow cursor/index registers
    // stay width-exact.
    localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
    localparam logic [10:0] SCR_LAST = 11'(SCR_SIZE - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

endpackage

// File: rtl/vt100_term_writer_if.sv
// Byte-stream input handshake plus the screen-buffer write port.
// Handshake: a byte moves when i_valid and o_ready are both high at a rising
// clock edge; the sender holds i_data/i_valid stable until that edge, and
// o_ready does not depend combinationally on i_valid.
interface vt100_term_writer_if;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        o_ready;
    logic [10:0] o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_wr;

    // Byte source / buffer sink side.
    modport master (
        output i_data, i_valid,
        input  o_ready, o_wr_addr, o_wr_data, o_wr
    );

    // Write engine side.
    modport slave (
        input  i_data, i_valid,
        output o_ready, o_wr_addr, o_wr_data, o_wr
    );
endinterface

// File: rtl/vt100_addr_gen.sv
// Logical (row, col) to screen-buffer address, honouring the circular top row.
// Shared with the display address path.
module vt100_addr_gen
    import vt100_pkg::*;
(
    input  logic [4:0]  top_row,
    input  logic [4:0]  row,
    input  logic [6:0]  col,
    output logic [10:0] addr
);
    logic [5:0] sum;
    logic [4:0] phys;

    // Both operands are below ROWS, so one conditional subtract gives mod ROWS.
    always_comb begin
        sum  = {1'b0, top_row} + {1'b0, row};
        phys = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
        addr = ({6'd0, phys} * 11'(COLS)) + {4'd0, col};
    end
endmodule

// File: rtl/vt100_term_writer.sv
// Terminal write engine: decodes a byte stream into screen-buffer writes,
// tracks the cursor, scrolls by rotating the top-row pointer.
module vt100_term_writer
    import vt100_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    vt100_term_writer_if.slave  bus,
    output logic [4:0]          o_top_row,
    output logic [6:0]          o_cur_col,
    output logic [4:0]          o_cur_row,
    output state_t              o_dbg_state
);
    state_t      state_q, state_n;
    logic [10:0] clr_idx_q, clr_idx_n;
    logic [4:0]  top_q, top_n, row_q, row_n;
    logic [6:0]  col_q, col_n;
    logic        ready_q, ready_n, wr_q, wr_n;
    logic [10:0] addr_q, addr_n;
    logic [7:0]  data_q, data_n;
    logic [4:0]  ag_row;
    logic [6:0]  ag_col;
    logic [10:0] ag_addr;
    logic        do_nl;

    vt100_addr_gen u_addr_gen (
        .top_row (top_q),
        .row     (ag_row),
        .col     (ag_col),
        .addr    (ag_addr)
    );

    // State and registered outputs; reset starts a full-screen clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= CLR_ALL;
            clr_idx_q <= '0;
            top_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ready_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= FILL;
        end else begin
            state_q   <= state_n;
            clr_idx_q <= clr_idx_n;
            top_q     <= top_n;
            row_q     <= row_n;
            col_q     <= col_n;
            ready_q   <= ready_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
        end
    end

    // Next-state, cursor update and write generation.
    always_comb begin
        state_n   = state_q;
        clr_idx_n = clr_idx_q;
        top_n     = top_q;
        row_n     = row_q;
        col_n     = col_q;
        ready_n   = 1'b0;
        wr_n      = 1'b0;
        addr_n    = addr_q;
        data_n    = data_q;
        ag_row    = row_q;
        ag_col    = col_q;
        do_nl     = 1'b0;
        case (state_q)
            CLR_ALL: begin
                wr_n   = 1'b1;
                addr_n = clr_idx_q;
                data_n = FILL;
                if (clr_idx_q == SCR_LAST) begin
                    state_n   = IDLE;
                    clr_idx_n = '0;
                    top_n     = '0;
                    row_n     = '0;
                    col_n     = '0;
                end else begin
                    clr_idx_n = clr_idx_q + 11'd1;
                end
            end
            CLR_ROW: begin
                // Logical row 0 is the physical row being recycled.
                ag_row = '0;
                ag_col = clr_idx_q[6:0];
                wr_n   = 1'b1;
                addr_n = ag_addr;
                data_n = FILL;
                if (clr_idx_q[6:0] == COL_LAST) begin
                    state_n   = IDLE;
                    clr_idx_n = '0;
                    top_n     = (top_q == ROW_LAST) ? 5'd0 : top_q + 5'd1;
                end else begin
                    clr_idx_n = clr_idx_q + 11'd1;
                end
            end
            IDLE: begin
                ready_n = 1'b1;
                if (bus.i_valid && ready_q) begin
                    if (bus.i_data >= 8'h20 && bus.i_data <= 8'h7E) begin
                        wr_n   = 1'b1;
                        addr_n = ag_addr;
                        data_n = bus.i_data;
                        if (col_q < COL_LAST) begin
                            col_n = col_q + 7'd1;
                        end else begin
                            col_n = '0;
                            do_nl = 1'b1;
                        end
                    end else if (bus.i_data == CH_CR) begin
                        col_n = '0;
                    end else if (bus.i_data == CH_LF) begin
                        do_nl = 1'b1;
                    end else if (bus.i_data == CH_BS) begin
                        if (col_q != '0) col_n = col_q - 7'd1;
                    end else if (bus.i_data == CH_FF) begin
                        state_n   = CLR_ALL;
                        clr_idx_n = '0;
                        ready_n   = 1'b0;
                    end
                    if (do_nl) begin
                        if (row_q < ROW_LAST) begin
                            row_n = row_q + 5'd1;
                        end else begin
                            state_n   = CLR_ROW;
                            clr_idx_n = '0;
                            ready_n   = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n   = CLR_ALL;
                clr_idx_n = '0;
            end
        endcase
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_wr      = wr_q;
    assign bus.o_wr_addr = addr_q;
    assign bus.o_wr_data = data_q;
    assign o_top_row     = top_q;
    assign o_cur_col     = col_q;
    assign o_cur_row     = row_q;
    assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_vt100_term_writer.sv
// Bench for vt100_term_writer: reference terminal model producing an ordered
// list of expected buffer writes and the expected cursor/top row.
module tb_vt100_term_writer;
    import vt100_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] o_top_row;
    logic [6:0] o_cur_col;
    logic [4:0] o_cur_row;
    state_t     dbg_state;

    vt100_term_writer_if bus();

    vt100_term_writer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .o_top_row   (o_top_row),
        .o_cur_col   (o_cur_col),
        .o_cur_row   (o_cur_row),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset
    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int last_addr = -1;
    int last_data = -1;

    // Scoreboard: {addr, data} of every write the buffer must see, in order.
    logic [18:0] exp_q[$];

    // Reference terminal state.
    int m_top = 0, m_row = 0, m_col = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push_wr(input int addr, input int data);
        exp_q.push_back({11'(addr), 8'(data)});
    endfunction

    function automatic void model_clear_all();
        for (int i = 0; i < SCR_SIZE; i++) push_wr(i, 32);
        m_top = 0; m_row = 0; m_col = 0;
    endfunction

    function automatic void model_newline();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            for (int i = 0; i < COLS; i++) push_wr(m_top * COLS + i, 32);
            m_top = (m_top + 1) % ROWS;
        end
    endfunction

    function automatic void model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(((m_top + m_row) % ROWS) * COLS + m_col, int'(b));
            if (m_col < COLS - 1) m_col++;
            else begin m_col = 0; model_newline(); end
        end else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) model_newline();
        else if (b == 8'h08) begin if (m_col > 0) m_col--; end
        else if (b == 8'h0C) model_clear_all();
    endfunction

    // Compare process: every write against the scoreboard, plus range checks.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (o_cur_col > 7'd79 || o_cur_row > 5'd23 || o_top_row > 5'd23) begin
                errors++;
                $display("FAIL range: col=%0d row=%0d top=%0d", o_cur_col, o_cur_row, o_top_row);
            end
            if (bus.o_wr) begin
                checks++;
                wr_cnt++;
                last_addr = int'(bus.o_wr_addr);
                last_data = int'(bus.o_wr_data);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h", bus.o_wr_addr, bus.o_wr_data);
                end else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    if ({bus.o_wr_addr, bus.o_wr_data} !== e) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.o_wr_addr, bus.o_wr_data, e[18:8], e[7:0]);
                    end
                end
            end
        end
    end

    // Driver: call at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        while (!bus.o_ready && n < 5000) begin @(negedge clk); n++; end
        if (!bus.o_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready=%0d required 1", bus.o_ready);
            bus.i_valid = 1'b0;
            return;
        end
        model_apply(b);
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Wait until the engine is idle again, then compare cursor state.
    task automatic settle();
        int n = 0;
        while (!bus.o_ready && n < 5000) begin @(negedge clk); n++; end
        #1;
        check("settle_ready", int'(bus.o_ready), 1);
        check("top_row", int'(o_top_row), m_top);
        check("cur_col", int'(o_cur_col), m_col);
        check("cur_row", int'(o_cur_row), m_row);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        int n = 0, w = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("rst_ready", int'(bus.o_ready), 0);
        check("rst_wr", int'(bus.o_wr), 0);
        check("rst_addr", int'(bus.o_wr_addr), 0);
        check("rst_data", int'(bus.o_wr_data), 32);
        check("rst_top", int'(o_top_row), 0);
        check("rst_col", int'(o_cur_col), 0);
        check("rst_row", int'(o_cur_row), 0);
        check("rst_state", int'(dbg_state), int'(CLR_ALL));
        repeat (3) @(negedge clk);
        model_clear_all();
        rst = 1'b0;
        while (!bus.o_ready && n < 4000) begin
            @(negedge clk);
            n++;
            if (bus.o_wr) w++;
        end
        check("clear_cycles_to_ready", n, 1921);
        check("clear_write_count", w, 1920);
    endtask

    initial begin
        int c0;
        logic [7:0] b;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;

        // Power-up clear
        apply_reset();
        settle();

        // Basic printable / CR / LF / BS
        send_byte(8'h41); settle();
        check("A_addr", last_addr, 0);
        check("A_data", last_data, 8'h41);
        send_byte(8'h0D); send_byte(8'h0A); send_byte(8'h42); settle();
        check("B_addr", last_addr, 80);
        check("B_data", last_data, 8'h42);
        check("B_col", int'(o_cur_col), 1);
        check("B_row", int'(o_cur_row), 1);
        send_byte(8'h0D);
        c0 = wr_cnt;
        send_byte(8'h08); settle();
        check("bs_col0", int'(o_cur_col), 0);
        check("bs_no_write", wr_cnt - c0, 0);

        // Row wrap on the 80th printable
        send_byte(8'h0C); settle();
        for (int i = 0; i < 80; i++) send_byte(8'h78);
        settle();
        check("wrap_last_addr", last_addr, 79);
        check("wrap_col", int'(o_cur_col), 0);
        check("wrap_row", int'(o_cur_row), 1);
        send_byte(8'h79); settle();
        check("wrap_next_addr", last_addr, 80);

        // Scroll from the bottom row
        send_byte(8'h0C); settle();
        for (int i = 0; i < 23; i++) send_byte(8'h0A);
        settle();
        check("bottom_row", int'(o_cur_row), 23);
        c0 = wr_cnt;
        send_byte(8'h0A); settle();
        check("scroll_writes", wr_cnt - c0, 80);
        check("scroll_top", int'(o_top_row), 1);
        check("scroll_row", int'(o_cur_row), 23);
        send_byte(8'h5A); settle();
        check("Z_addr", last_addr, 0);
        check("Z_data", last_data, 8'h5A);

        // Remaining scrolls of a full rotation
        for (int k = 2; k <= 24; k++) begin
            send_byte(8'h0A); settle();
            check("rot_top", int'(o_top_row), k % 24);
        end

        // Bottom-right printable: written row survives, old top row cleared
        send_byte(8'h0D);
        for (int i = 0; i < 79; i++) send_byte(8'h2E);
        send_byte(8'h51); settle();
        check("br_top", int'(o_top_row), 1);
        check("br_col", int'(o_cur_col), 0);

        // Randomized byte stream
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 78) b = 8'h0D;
            else if (r < 88) b = 8'h0A;
            else if (r < 94) b = 8'h08;
            else if (r < 95) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
            if ($urandom_range(0, 3) == 0) settle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        settle();

        // Reset in the middle of a form-feed clear
        send_byte(8'h0C);
        repeat (500) @(negedge clk);
        apply_reset();
        settle();
        check("final_top", int'(o_top_row), 0);
        check("final_col", int'(o_cur_col), 0);
        check("final_row", int'(o_cur_row), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
